zf_qam_demapper: RTL

Hard-decision QAM demapper at the downstream end of the zero-forcing preprocess stage in the 2x2 MIMO detector. It takes the 128-bit equalised vector, eight signed 16-bit real components, over the upstream ready/accept handshake. It slices the components one per cycle onto a Gray-coded PAM grid and presents the packed bits to the bit sink with a valid/accept handshake.

---
 rtl/zf_pkg.sv | 26 ++
 rtl/zf_qam_demapper_if.sv | 22 ++
 rtl/zf_pam_slicer.sv | 48 ++++
 rtl/zf_qam_demapper.sv | 105 ++++++++++
 4 files changed

// File: rtl/zf_pkg.sv
// Shared definitions for the zero-forcing QAM demapper: FSM states, Gray codes,
// PAM level multiples and the error-accumulator width.
package zf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SLICE,
      OUT
   } state_t;

   // Gray mapping on the 4-PAM grid, outer points differ from neighbours by one bit
   localparam logic [1:0] GRAY_P3 = 2'b10;
   localparam logic [1:0] GRAY_P1 = 2'b11;
   localparam logic [1:0] GRAY_M1 = 2'b01;
   localparam logic [1:0] GRAY_M3 = 2'b00;
   localparam logic       GRAY_POS = 1'b1;
   localparam logic       GRAY_NEG = 1'b0;

   localparam int LVL_1 = 1;
   localparam int LVL_2 = 2;
   localparam int LVL_3 = 3;

   localparam int ERR_W      = 20;
   localparam int ERR_TERM_W = 17;

endpackage

// File: rtl/zf_qam_demapper_if.sv
// Upstream vector handshake and downstream bit-sink handshake of the demapper.
interface zf_qam_demapper_if #(
   parameter int DATA_W       = 16,
   parameter int BITS_PER_DIM = 2
);
   logic [8*DATA_W-1:0]       data_in;
   logic                      data_ready_in;
   logic                      data_accept_out;
   logic [8*BITS_PER_DIM-1:0] bits_out;
   logic                      bits_valid;
   logic                      bits_accept;

   modport slave (
      input  data_in, data_ready_in, bits_accept,
      output data_accept_out, bits_out, bits_valid
   );

   modport master (
      output data_in, data_ready_in, bits_accept,
      input  data_accept_out, bits_out, bits_valid
   );
endinterface

// File: rtl/zf_pam_slicer.sv
// Combinational hard-decision slicer for one real component onto the Gray PAM grid;
// returns the Gray code and the reconstructed level (in units of 1<<FRAC_W).
module zf_pam_slicer
   import zf_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FRAC_W       = 8,
   parameter int BITS_PER_DIM = 2
) (
   input  logic signed [DATA_W-1:0]  v,
   output logic [BITS_PER_DIM-1:0]   code,
   output logic signed [2:0]         level
);

   localparam logic signed [DATA_W-1:0] T_POS2 = DATA_W'(LVL_2 << FRAC_W);
   localparam logic signed [DATA_W-1:0] T_NEG2 = DATA_W'(-(LVL_2 << FRAC_W));
   localparam logic signed [DATA_W-1:0] ZERO   = '0;

   generate
      if (BITS_PER_DIM == 2) begin : g_pam4
         // Outer decisions absorb any magnitude, so the full input range saturates cleanly
         always_comb begin
            code  = GRAY_M3;
            level = -3'(LVL_3);
            if (v >= T_POS2) begin
               code  = GRAY_P3;
               level = 3'(LVL_3);
            end else if (v >= ZERO) begin
               code  = GRAY_P1;
               level = 3'(LVL_1);
            end else if (v >= T_NEG2) begin
               code  = GRAY_M1;
               level = -3'(LVL_1);
            end
         end
      end else begin : g_pam2
         always_comb begin
            code  = GRAY_NEG;
            level = -3'(LVL_1);
            if (v >= ZERO) begin
               code  = GRAY_POS;
               level = 3'(LVL_1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/zf_qam_demapper.sv
// Hard-decision QAM demapper: captures an 8-component vector, slices one component per
// cycle and presents packed Gray bits. Optional macro ZF_DEMAP_ERR_EN adds err_sum.
module zf_qam_demapper
   import zf_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FRAC_W       = 8,
   parameter int BITS_PER_DIM = 2
) (
   input  logic               clk,
   input  logic               reset,
   zf_qam_demapper_if.slave   bus,
   output logic               busy
`ifdef ZF_DEMAP_ERR_EN
   ,
   output logic [ERR_W-1:0]   err_sum
`endif
);

   localparam int VEC_W = 8 * DATA_W;
   localparam int BIT_W = 8 * BITS_PER_DIM;

   state_t                    state;
   state_t                    next_state;
   logic [2:0]                idx;
   logic [VEC_W-1:0]          shreg;
   logic signed [DATA_W-1:0]  elem;
   logic [BITS_PER_DIM-1:0]   code;
   logic signed [2:0]         level;
   logic                      capture;

   assign capture             = (state == IDLE) && bus.data_ready_in;
   assign bus.data_accept_out = capture;
   assign busy                = (state != IDLE);
   assign elem                = shreg[VEC_W-1 -: DATA_W];

   zf_pam_slicer #(
      .DATA_W       (DATA_W),
      .FRAC_W       (FRAC_W),
      .BITS_PER_DIM (BITS_PER_DIM)
   ) u_slicer (
      .v     (elem),
      .code  (code),
      .level (level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.data_ready_in) next_state = SLICE;
         SLICE:   if (idx == 3'd7)       next_state = OUT;
         OUT:     if (bus.bits_accept)   next_state = IDLE;
         default:                        next_state = IDLE;
      endcase
   end

   // Element 0 sits in the MSBs of both the input vector and bits_out, so both shift left
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx            <= '0;
         shreg          <= '0;
         bus.bits_out   <= '0;
         bus.bits_valid <= 1'b0;
      end else if (capture) begin
         shreg <= bus.data_in;
         idx   <= '0;
      end else if (state == SLICE) begin
         shreg        <= shreg << DATA_W;
         bus.bits_out <= {bus.bits_out[BIT_W-BITS_PER_DIM-1:0], code};
         idx          <= idx + 3'd1;
         if (idx == 3'd7) bus.bits_valid <= 1'b1;
      end else if ((state == OUT) && bus.bits_accept) begin
         bus.bits_valid <= 1'b0;
      end
   end

`ifdef ZF_DEMAP_ERR_EN
   logic signed [DATA_W+1:0] v_ext;
   logic signed [DATA_W+1:0] recon;
   logic signed [DATA_W+1:0] diff;
   logic [ERR_TERM_W-1:0]    mag;

   always_comb begin
      v_ext = {{2{elem[DATA_W-1]}}, elem};
      recon = {{(DATA_W-1){level[2]}}, level} <<< FRAC_W;
      diff  = v_ext - recon;
      mag   = diff[DATA_W+1] ? ERR_TERM_W'(-diff) : ERR_TERM_W'(diff);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               err_sum <= '0;
      else if (capture)        err_sum <= '0;
      else if (state == SLICE) err_sum <= err_sum + {{(ERR_W-ERR_TERM_W){1'b0}}, mag};
   end
`else
   logic unused_level;
   assign unused_level = ^level;
`endif

endmodule
